// File: rtl/stream_sync_gate.sv
// stream_sync_gate: frame gate and stream checker for the multi-channel pixel stream.
// Stage 1 registers fval/lval/data and the enable condition; edges are taken from the
// registered copies. Stage 2 applies the gating FSM and drives the registered outputs.
// Only complete frames that start at a frame boundary are passed. Line count and
// line length are measured per frame, and a sticky error flags any line whose length
// differs from the first line.
module stream_sync_gate #(
    parameter int    DATA_WIDTH  = 10,
    parameter int    CHANNEL_NUM = 4,
    parameter int    CNT_WIDTH   = 16,
    parameter string GATE_MODE   = "FRAME"
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              i_clk_en,
    input  logic                              i_fval,
    input  logic                              i_lval,
    input  logic [DATA_WIDTH*CHANNEL_NUM-1:0] iv_pix_data,
    input  logic                              i_acq_en,
    input  logic                              i_encrypt_ok,
    output logic                              o_fval,
    output logic                              o_lval,
    output logic [DATA_WIDTH*CHANNEL_NUM-1:0] ov_pix_data,
    output logic [CNT_WIDTH-1:0]              ov_line_cnt,
    output logic [CNT_WIDTH-1:0]              ov_line_len,
    output logic                              o_frame_done,
    output logic                              o_line_err
);

    localparam int PIX_W     = DATA_WIDTH * CHANNEL_NUM;
    localparam bit IMMEDIATE = (GATE_MODE == "IMMEDIATE");

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_DRAIN  = 2'd3
    } state_t;

    // Counters stop at all-ones instead of wrapping.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Stage 1 registers.
    logic             fval_p1_q, fval_p1_d;
    logic             lval_p1_q, lval_p1_d;
    logic             fval_dly_p1_q, fval_dly_p1_d;
    logic             lval_dly_p1_q, lval_dly_p1_d;
    logic             en_ok_p1_q, en_ok_p1_d;
    logic [PIX_W-1:0] data_p1_q, data_p1_d;

    // Stage 2 control and outputs.
    state_t               state_q, state_d;
    logic                 out_fval_q, out_fval_d;
    logic                 out_lval_q, out_lval_d;
    logic [PIX_W-1:0]     out_pix_q, out_pix_d;
    logic [CNT_WIDTH-1:0] out_line_cnt_q, out_line_cnt_d;
    logic [CNT_WIDTH-1:0] out_line_len_q, out_line_len_d;
    logic                 out_done_q, out_done_d;
    logic                 line_err_q, line_err_d;
    logic [CNT_WIDTH-1:0] pix_cnt_q, pix_cnt_d;
    logic [CNT_WIDTH-1:0] line_cnt_q, line_cnt_d;
    logic [CNT_WIDTH-1:0] len_q, len_d;
    logic                 first_line_q, first_line_d;
    logic                 stop_pend_q, stop_pend_d;

    // Edge detection on the registered stream; lval is masked by fval.
    logic mlval_cur, mlval_prev, fval_rise, fval_fall, line_start, line_end;
    assign mlval_cur  = lval_p1_q & fval_p1_q;
    assign mlval_prev = lval_dly_p1_q & fval_dly_p1_q;
    assign fval_rise  = fval_p1_q & ~fval_dly_p1_q;
    assign fval_fall  = ~fval_p1_q & fval_dly_p1_q;
    assign line_start = mlval_cur & ~mlval_prev;
    assign line_end   = ~mlval_cur & mlval_prev;

    logic frame_start;
    logic pass;

    // Next-state, counting and output computation; everything holds on disabled beats.
    always_comb begin
        fval_p1_d      = fval_p1_q;
        lval_p1_d      = lval_p1_q;
        fval_dly_p1_d  = fval_dly_p1_q;
        lval_dly_p1_d  = lval_dly_p1_q;
        en_ok_p1_d     = en_ok_p1_q;
        data_p1_d      = data_p1_q;
        state_d        = state_q;
        out_fval_d     = out_fval_q;
        out_lval_d     = out_lval_q;
        out_pix_d      = out_pix_q;
        out_line_cnt_d = out_line_cnt_q;
        out_line_len_d = out_line_len_q;
        out_done_d     = 1'b0;
        line_err_d     = line_err_q;
        pix_cnt_d      = pix_cnt_q;
        line_cnt_d     = line_cnt_q;
        len_d          = len_q;
        first_line_d   = first_line_q;
        stop_pend_d    = stop_pend_q;
        frame_start    = 1'b0;
        pass           = 1'b0;

        if (i_clk_en) begin
            // ---- stage 1: capture inputs and keep one beat of history ----
            fval_p1_d     = i_fval;
            lval_p1_d     = i_lval;
            fval_dly_p1_d = fval_p1_q;
            lval_dly_p1_d = lval_p1_q;
            en_ok_p1_d    = i_acq_en & i_encrypt_ok;
            data_p1_d     = iv_pix_data;

            // ---- stage 2: gating FSM ----
            case (state_q)
                ST_IDLE: begin
                    // A frame running at reset release must finish before we arm.
                    if (!i_fval) state_d = ST_WAIT;
                end
                ST_WAIT: begin
                    if (fval_rise && en_ok_p1_q) begin
                        frame_start = 1'b1;
                        pass        = 1'b1;
                        state_d     = ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    pass = 1'b1;
                    if (IMMEDIATE && (stop_pend_q || !en_ok_p1_q)) begin
                        // Let the current line finish, then cut the frame.
                        if (mlval_cur) begin
                            stop_pend_d = 1'b1;
                        end else begin
                            pass    = 1'b0;
                            state_d = ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (!fval_p1_q) state_d = ST_WAIT;
                end
                default: state_d = ST_IDLE;
            endcase

            if (frame_start) begin
                line_cnt_d   = '0;
                len_d        = '0;
                line_err_d   = 1'b0;
                first_line_d = 1'b1;
                stop_pend_d  = 1'b0;
                pix_cnt_d    = '0;
            end

            if (frame_start || state_q == ST_ACTIVE) begin
                if (mlval_cur) pix_cnt_d = line_start ? CNT_WIDTH'(1) : sat_inc(pix_cnt_q);
                // A line truncated by the fval fall ends here too and is checked.
                if (line_end) begin
                    if (first_line_q) begin
                        len_d        = pix_cnt_q;
                        first_line_d = 1'b0;
                    end else if (pix_cnt_q != len_q) begin
                        line_err_d = 1'b1;
                    end
                    line_cnt_d = sat_inc(line_cnt_q);
                end
                if (state_q == ST_ACTIVE && state_d == ST_ACTIVE && fval_fall) begin
                    out_line_cnt_d = line_cnt_d;
                    out_line_len_d = len_d;
                    out_done_d     = 1'b1;
                    state_d        = ST_WAIT;
                end
            end

            out_fval_d = pass & fval_p1_q;
            out_lval_d = pass & mlval_cur;
            out_pix_d  = (pass && mlval_cur) ? data_p1_q : '0;
        end
    end

    // Control and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fval_p1_q      <= 1'b0;
            lval_p1_q      <= 1'b0;
            fval_dly_p1_q  <= 1'b0;
            lval_dly_p1_q  <= 1'b0;
            en_ok_p1_q     <= 1'b0;
            state_q        <= ST_IDLE;
            out_fval_q     <= 1'b0;
            out_lval_q     <= 1'b0;
            out_pix_q      <= '0;
            out_line_cnt_q <= '0;
            out_line_len_q <= '0;
            out_done_q     <= 1'b0;
            line_err_q     <= 1'b0;
            pix_cnt_q      <= '0;
            line_cnt_q     <= '0;
            len_q          <= '0;
            first_line_q   <= 1'b0;
            stop_pend_q    <= 1'b0;
        end else begin
            fval_p1_q      <= fval_p1_d;
            lval_p1_q      <= lval_p1_d;
            fval_dly_p1_q  <= fval_dly_p1_d;
            lval_dly_p1_q  <= lval_dly_p1_d;
            en_ok_p1_q     <= en_ok_p1_d;
            state_q        <= state_d;
            out_fval_q     <= out_fval_d;
            out_lval_q     <= out_lval_d;
            out_pix_q      <= out_pix_d;
            out_line_cnt_q <= out_line_cnt_d;
            out_line_len_q <= out_line_len_d;
            out_done_q     <= out_done_d;
            line_err_q     <= line_err_d;
            pix_cnt_q      <= pix_cnt_d;
            line_cnt_q     <= line_cnt_d;
            len_q          <= len_d;
            first_line_q   <= first_line_d;
            stop_pend_q    <= stop_pend_d;
        end
    end

    // Stage-1 pixel data needs no reset: it only reaches the output while lval is gated on.
    always_ff @(posedge clk) begin
        data_p1_q <= data_p1_d;
    end

    assign o_fval       = out_fval_q;
    assign o_lval       = out_lval_q;
    assign ov_pix_data  = out_pix_q;
    assign ov_line_cnt  = out_line_cnt_q;
    assign ov_line_len  = out_line_len_q;
    assign o_frame_done = out_done_q;
    assign o_line_err   = line_err_q;

endmodule

// File: tb/tb_stream_sync_gate.sv
// Bench for stream_sync_gate: one FRAME-mode and one IMMEDIATE-mode instance share
// the same directed input stream; a monitor tallies what each instance emits.
module tb_stream_sync_gate;

    localparam int W = 40;

    logic clk = 1'b0;
    logic reset_n;
    logic i_clk_en, i_fval, i_lval, i_acq_en, i_encrypt_ok;
    logic [W-1:0] iv_pix_data;

    logic         o_fval [2];
    logic         o_lval [2];
    logic [W-1:0] ov_pix_data [2];
    logic [15:0]  ov_line_cnt [2];
    logic [15:0]  ov_line_len [2];
    logic         o_frame_done [2];
    logic         o_line_err [2];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    stream_sync_gate #(.GATE_MODE("FRAME")) u_frame (
        .clk(clk), .reset_n(reset_n), .i_clk_en(i_clk_en), .i_fval(i_fval), .i_lval(i_lval),
        .iv_pix_data(iv_pix_data), .i_acq_en(i_acq_en), .i_encrypt_ok(i_encrypt_ok),
        .o_fval(o_fval[0]), .o_lval(o_lval[0]), .ov_pix_data(ov_pix_data[0]),
        .ov_line_cnt(ov_line_cnt[0]), .ov_line_len(ov_line_len[0]),
        .o_frame_done(o_frame_done[0]), .o_line_err(o_line_err[0]));

    stream_sync_gate #(.GATE_MODE("IMMEDIATE")) u_imm (
        .clk(clk), .reset_n(reset_n), .i_clk_en(i_clk_en), .i_fval(i_fval), .i_lval(i_lval),
        .iv_pix_data(iv_pix_data), .i_acq_en(i_acq_en), .i_encrypt_ok(i_encrypt_ok),
        .o_fval(o_fval[1]), .o_lval(o_lval[1]), .ov_pix_data(ov_pix_data[1]),
        .ov_line_cnt(ov_line_cnt[1]), .ov_line_len(ov_line_len[1]),
        .o_frame_done(o_frame_done[1]), .o_line_err(o_line_err[1]));

    task automatic chk(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic string nm(input string s, input int d);
        return $sformatf("%s_%s", s, (d == 0) ? "frame" : "imm");
    endfunction

    function automatic logic [W-1:0] mk(input int l, input int b);
        logic [19:0] v;
        v = 20'(l * 256 + b + 1);
        return {v, v};
    endfunction

    // Beat bookkeeping: cycle count and whether the last edge was an enabled one.
    int cyc = 0;
    logic en_seen = 1'b0;
    initial forever begin
        @(posedge clk);
        cyc++;
        en_seen = i_clk_en;
    end

    // Output monitor, sampled on the falling edge after each enabled beat.
    int frames [2] = '{0, 0};
    int rises [2] = '{0, 0};
    int lines_out [2], beats_cur [2], beats_tot [2];
    int last_lines [2] = '{0, 0};
    int last_beats [2] = '{0, 0};
    int err_line [2] = '{-1, -1};
    int done_cyc [2] = '{0, 0};
    int data_bad [2] = '{0, 0};
    logic pf [2] = '{1'b0, 1'b0};
    logic pl [2] = '{1'b0, 1'b0};
    logic pe [2] = '{1'b0, 1'b0};

    initial forever begin
        @(negedge clk);
        if (en_seen) begin
            for (int d = 0; d < 2; d++) begin
                if (o_fval[d] && !pf[d]) begin
                    rises[d]++;
                    lines_out[d] = 0;
                    beats_cur[d] = 0;
                    beats_tot[d] = 0;
                    err_line[d]  = -1;
                end
                if (o_lval[d]) begin
                    if (ov_pix_data[d] !== mk(lines_out[d], beats_cur[d])) data_bad[d]++;
                    if (!o_fval[d]) data_bad[d]++;
                    beats_cur[d]++;
                    beats_tot[d]++;
                end else begin
                    if (ov_pix_data[d] !== '0) data_bad[d]++;
                    if (pl[d]) begin
                        lines_out[d]++;
                        beats_cur[d] = 0;
                    end
                end
                if (o_line_err[d] && !pe[d]) err_line[d] = lines_out[d];
                if (!o_fval[d] && pf[d]) begin
                    last_lines[d] = lines_out[d];
                    last_beats[d] = beats_tot[d];
                end
                if (o_frame_done[d]) begin
                    frames[d]++;
                    done_cyc[d] = cyc;
                end
                pf[d] = o_fval[d];
                pl[d] = o_lval[d];
                pe[d] = o_line_err[d];
            end
        end
    end

    // Stimulus state.
    logic acq_v = 1'b1;
    logic enc_v = 1'b1;
    bit   tog   = 1'b0;
    int   fall_cyc = 0;

    task automatic drive(input logic f, input logic l, input logic [W-1:0] dat);
        @(negedge clk);
        i_fval       = f;
        i_lval       = l;
        iv_pix_data  = dat;
        i_acq_en     = acq_v;
        i_encrypt_ok = enc_v;
        i_clk_en     = 1'b1;
        if (tog) begin
            @(negedge clk);
            i_clk_en = 1'b0;
        end
    endtask

    // One frame: 3 blank beats, fval lead beat, lines with 2-beat gaps, fval fall, 4 blank beats.
    task automatic send_frame(input int nl, input int ln, input int short_l, input int short_n,
                              input bit trunc, input int acq_drop, input int acq_rise,
                              input int enc_drop, input int rel);
        for (int k = 0; k < 3; k++) drive(1'b0, 1'b0, '0);
        drive(1'b1, 1'b0, '0);
        for (int l = 0; l < nl; l++) begin
            int n;
            n = (l == short_l) ? short_n : ln;
            if (l == rel) reset_n = 1'b1;
            if (l == acq_drop) acq_v = 1'b0;
            if (l == acq_rise) acq_v = 1'b1;
            for (int b = 0; b < n; b++) begin
                if (l == enc_drop && b == 3) enc_v = 1'b0;
                drive(1'b1, 1'b1, mk(l, b));
            end
            if (!(trunc && l == nl - 1)) begin
                drive(1'b1, 1'b0, '0);
                drive(1'b1, 1'b0, '0);
            end
        end
        drive(1'b0, 1'b0, '0);
        fall_cyc = cyc;
        for (int k = 0; k < 4; k++) drive(1'b0, 1'b0, '0);
        #2;
    endtask

    task automatic chk_frame(input int d, input string tag, input int exp_frames,
                             input int exp_cnt, input int exp_len, input int exp_err,
                             input int exp_lines, input int exp_beats);
        chk(nm({tag, "_frames"}, d), frames[d], exp_frames);
        chk(nm({tag, "_cnt"}, d), longint'(ov_line_cnt[d]), exp_cnt);
        chk(nm({tag, "_len"}, d), longint'(ov_line_len[d]), exp_len);
        chk(nm({tag, "_err"}, d), longint'(o_line_err[d]), exp_err);
        chk(nm({tag, "_lines"}, d), last_lines[d], exp_lines);
        chk(nm({tag, "_beats"}, d), last_beats[d], exp_beats);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n      = 1'b0;
        i_clk_en     = 1'b1;
        i_fval       = 1'b0;
        i_lval       = 1'b0;
        iv_pix_data  = '0;
        i_acq_en     = 1'b1;
        i_encrypt_ok = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk(nm("rst_fval", d), longint'(o_fval[d]), 0);
            chk(nm("rst_lval", d), longint'(o_lval[d]), 0);
            chk(nm("rst_data", d), longint'(ov_pix_data[d]), 0);
            chk(nm("rst_cnt", d), longint'(ov_line_cnt[d]), 0);
            chk(nm("rst_len", d), longint'(ov_line_len[d]), 0);
            chk(nm("rst_done", d), longint'(o_frame_done[d]), 0);
            chk(nm("rst_err", d), longint'(o_line_err[d]), 0);
        end

        // Reset released at line 3 of a running frame: nothing of it may appear.
        send_frame(16, 16, -1, 0, 1'b0, -1, -1, -1, 3);
        for (int d = 0; d < 2; d++) chk(nm("midrst_rises", d), rises[d], 0);

        // Two clean 16x16 frames.
        send_frame(16, 16, -1, 0, 1'b0, -1, -1, -1, -1);
        for (int d = 0; d < 2; d++) begin
            chk_frame(d, "clean1", 1, 16, 16, 0, 16, 256);
            chk(nm("clean1_done_lat", d), done_cyc[d] - fall_cyc, 2);
        end
        send_frame(16, 16, -1, 0, 1'b0, -1, -1, -1, -1);
        for (int d = 0; d < 2; d++) chk_frame(d, "clean2", 2, 16, 16, 0, 16, 256);

        // acq_en dropped at line 5: FRAME mode completes the frame.
        send_frame(16, 16, -1, 0, 1'b0, 5, -1, -1, -1);
        chk_frame(0, "acqdrop", 3, 16, 16, 0, 16, 256);

        // acq_en low at frame start, raised at line 8: frame skipped by both.
        send_frame(16, 16, -1, 0, 1'b0, -1, 8, -1, -1);
        chk(nm("acqlow_rises", 0), rises[0], 3);
        chk(nm("acqlow_rises", 1), rises[1], 3);

        // Next frame passes again.
        send_frame(16, 16, -1, 0, 1'b0, -1, -1, -1, -1);
        chk_frame(0, "resume", 4, 16, 16, 0, 16, 256);
        chk_frame(1, "resume", 3, 16, 16, 0, 16, 256);

        // encrypt_ok dropped during line 5: IMMEDIATE cuts after line 5, FRAME ignores.
        send_frame(16, 16, -1, 0, 1'b0, -1, -1, 5, -1);
        enc_v = 1'b1;
        chk_frame(0, "encdrop", 5, 16, 16, 0, 16, 256);
        chk_frame(1, "encdrop", 3, 16, 16, 0, 6, 96);
        chk(nm("encdrop_fval", 1), longint'(o_fval[1]), 0);

        // Line 7 shortened to 12 beats.
        send_frame(16, 16, 7, 12, 1'b0, -1, -1, -1, -1);
        for (int d = 0; d < 2; d++) begin
            chk_frame(d, "short", 6 - d * 2, 16, 16, 1, 16, 252);
            chk(nm("short_errline", d), err_line[d], 8);
        end

        // Clean frame clears the sticky error at its start.
        send_frame(16, 16, -1, 0, 1'b0, -1, -1, -1, -1);
        for (int d = 0; d < 2; d++) begin
            chk_frame(d, "clear", 7 - d * 2, 16, 16, 0, 16, 256);
            chk(nm("clear_errline", d), err_line[d], -1);
        end

        // fval falls while the last line (8 beats) is still active.
        send_frame(16, 16, 15, 8, 1'b1, -1, -1, -1, -1);
        for (int d = 0; d < 2; d++) begin
            chk_frame(d, "trunc", 8 - d * 2, 16, 16, 1, 16, 248);
            chk(nm("trunc_errline", d), err_line[d], 16);
        end

        // Clock enable toggling 1/0 with data held for two cycles.
        tog = 1'b1;
        send_frame(16, 16, -1, 0, 1'b0, -1, -1, -1, -1);
        tog = 1'b0;
        for (int d = 0; d < 2; d++) chk_frame(d, "clken", 9 - d * 2, 16, 16, 0, 16, 256);

        for (int d = 0; d < 2; d++) chk(nm("data_bad", d), data_bad[d], 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stream_sync_gate.md
Name: stream_sync_gate

Overview:
- Single-clock frame gate and stream checker for the multi-channel sensor pixel stream; sits directly after the sync buffer, in its output clock domain.
- Passes only complete frames, starting at a frame boundary, while acquisition is enabled and encryption is verified.
- Measures line count and line length per frame and flags lines whose length differs from the first line.
- Generalises the sync stage to any channel count/width, with a selectable gating mode and clock-enable qualified sampling.

Parameters:
- DATA_WIDTH, 10, bits per channel (8..16).
- CHANNEL_NUM, 4, parallel pixel channels (1..8).
- CNT_WIDTH, 16, width of line/pixel counters.
- GATE_MODE, "FRAME", "FRAME" = enable is sampled only at frame start; "IMMEDIATE" = enable also cuts a frame mid-stream at the next line end.

Ports:
- clk  input  1  pixel-domain clock.
- reset_n  input  1  asynchronous active-low reset.
- i_clk_en  input  1  beat qualifier; all sampling, counting and output updates occur only on cycles with i_clk_en=1.
- i_fval  input  1  frame valid in.
- i_lval  input  1  line valid in.
- iv_pix_data  input  DATA_WIDTH*CHANNEL_NUM  pixel data in.
- i_acq_en  input  1  acquisition enable.
- i_encrypt_ok  input  1  encryption check passed; gating requires 1.
- o_fval  output  1  gated frame valid.
- o_lval  output  1  gated line valid.
- ov_pix_data  output  DATA_WIDTH*CHANNEL_NUM  gated data; 0 when o_lval=0.
- ov_line_cnt  output  CNT_WIDTH  lines in last completed output frame.
- ov_line_len  output  CNT_WIDTH  beats in first line of last completed output frame.
- o_frame_done  output  1  one-clk pulse at falling edge of o_fval.
- o_line_err  output  1  sticky length-mismatch flag; cleared at next output frame start.

Behaviour:
- Reset: all outputs 0; state IDLE; counters 0.
- Latency: 2 enabled beats, input to output, for fval, lval and data alike. Stage 1 registers the inputs and detects edges; stage 2 applies gating.
- Edges are detected on registered i_fval/i_lval, qualified by i_clk_en. Cycles with i_clk_en=0 hold all state; o_frame_done never fires on them.
- State IDLE: wait for i_fval=0 on an enabled beat, then go to WAIT. A frame already in progress at reset release is never output.
- State WAIT: on an fval rising edge with i_acq_en=1 and i_encrypt_ok=1, go to ACTIVE and clear the line counter, length register and o_line_err. If the enables are low at the rising edge, the whole frame is skipped; stay in WAIT.
- State ACTIVE: o_fval follows registered fval. o_lval = registered lval AND registered fval; lval outside fval is masked.
  - Count lval beats per line.
  - At each lval falling edge:
    - First line: store the beat count in a length register.
    - Later lines: compare against the length register; set o_line_err on mismatch.
    - Increment the line counter.
- ACTIVE, frame end: on the fval falling edge, update ov_line_cnt and ov_line_len, pulse o_frame_done, return to WAIT.
- ACTIVE, fval falls while lval is high: the line is truncated and counted as a line; the length check applies.
- ACTIVE, mode "IMMEDIATE": if i_acq_en or i_encrypt_ok drops, the current line completes; o_fval then drops after that line's lval fall (data remains gated). Go to DRAIN, with no o_frame_done and no counter update.
- ACTIVE, mode "FRAME": enable drops mid-frame are ignored.
- State DRAIN: suppress outputs until the input fval falls, then go to WAIT.
- Counters saturate at all-ones, with no wrap.
- Simultaneous fval fall and rise on the same beat is impossible, since edges need one registered low beat. A one-beat fval low gap is a valid frame boundary.
- Reset mid-frame: outputs go to 0 at once; the block returns to IDLE.

Test Plan:
- Gating mode "FRAME", pattern 16x16, i_acq_en=i_encrypt_ok=1 from reset, i_clk_en=1: every frame after the first full blank passes. ov_line_cnt=16, ov_line_len=16, o_line_err=0. o_frame_done pulses once per frame, 2 clk after the input fval falls.
- Reset released mid-frame: that frame is fully suppressed (o_fval stays 0); the next frame passes intact.
- Gating mode "FRAME", i_acq_en dropped at line 5: the frame completes with 16 lines; the next frame is skipped. i_acq_en re-raised mid-frame: output resumes only at the following frame start.
- Gating mode "IMMEDIATE", i_encrypt_ok dropped during line 5: lines 0..5 are output complete, then o_fval falls. There is no o_frame_done, and ov_line_cnt keeps its prior value of 16.
- Line 7 shortened to 12 beats: o_line_err=1 from that line's end until the next frame start; ov_line_len=16.
- i_clk_en toggling 1/0 with data held over 2 cycles: output is identical to the i_clk_en=1 case when sampled on enabled beats. Counts are 16/16 with no double counting.
